fp32_mult: RTL and testbench

- Pipelined IEEE-754 single-precision multiplier used as the per-PE float multiply inside the processing-element datapath.
- Accepts two binary32 operands with a valid strobe.
- Returns the correctly rounded product (round-to-nearest-even) two clock cycles later with a matching valid strobe.
- Subnormals are flushed to zero; special values are handled.

---
 rtl/fp32_mult.sv | 137 +++++++++++++
 tb/tb_fp32_mult.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mult.sv
// fp32_mult: two-stage pipelined IEEE-754 binary32 multiplier.
// Rounds to nearest-even, flushes subnormal inputs and outputs to zero,
// and returns a single canonical NaN.
module fp32_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] m
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned ESUM_W = EXP_W + 2;
    localparam int unsigned EFIN_W = EXP_W + 3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Stage 1 registers
    logic                     v1_q, v1_d;
    logic                     sign1_q, sign1_d;
    logic                     nan1_q, nan1_d;
    logic                     inf1_q, inf1_d;
    logic                     zero1_q, zero1_d;
    logic signed [ESUM_W-1:0] exp1_q, exp1_d;
    logic [PROD_W-1:0]        prod1_q, prod1_d;

    // Stage 2 (output) registers
    logic                     v2_q, v2_d;
    logic [31:0]              m_q, m_d;

    // Stage 1: classify operands, XOR signs, sum exponents, multiply significands
    always_comb begin
        logic [EXP_W-1:0] ea, eb;
        logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        ea     = a[30:23];
        eb     = b[30:23];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (a[22:0] == '0);
        b_inf  = (eb == '1) && (b[22:0] == '0);
        a_nan  = (ea == '1) && (a[22:0] != '0);
        b_nan  = (eb == '1) && (b[22:0] != '0);

        v1_d    = in_valid;
        sign1_d = a[31] ^ b[31];
        nan1_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        inf1_d  = a_inf || b_inf;
        zero1_d = a_zero || b_zero;
        exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - ESUM_W'(127);
        prod1_d = PROD_W'({1'b1, a[22:0]}) * PROD_W'({1'b1, b[22:0]});
    end

    // Stage 2: normalize, round to nearest-even, handle range and specials, pack
    always_comb begin
        logic [SIG_W-1:0]         sig;
        logic                     guard, sticky, rnd;
        logic [SIG_W:0]           sig_r;
        logic [FRAC_W-1:0]        frac;
        logic signed [EFIN_W-1:0] e_n, e_f;
        logic [31:0]              res;

        if (prod1_q[PROD_W-1]) begin
            sig    = prod1_q[47:24];
            guard  = prod1_q[23];
            sticky = |prod1_q[22:0];
            e_n    = {exp1_q[ESUM_W-1], exp1_q} + EFIN_W'(1);
        end else begin
            sig    = prod1_q[46:23];
            guard  = prod1_q[22];
            sticky = |prod1_q[21:0];
            e_n    = {exp1_q[ESUM_W-1], exp1_q};
        end

        rnd   = guard & (sticky | sig[0]);
        sig_r = {1'b0, sig} + (SIG_W+1)'(rnd);

        // A rounding carry leaves 1.000..0, so the fraction clears
        if (sig_r[SIG_W]) begin
            frac = '0;
            e_f  = e_n + EFIN_W'(1);
        end else begin
            frac = sig_r[FRAC_W-1:0];
            e_f  = e_n;
        end

        if (nan1_q) begin
            res = QNAN;
        end else if (inf1_q) begin
            res = {sign1_q, 8'hFF, 23'd0};
        end else if (zero1_q) begin
            res = {sign1_q, 31'd0};
        end else if (e_f >= EFIN_W'(255)) begin
            res = {sign1_q, 8'hFF, 23'd0};
        end else if (e_f <= EFIN_W'(0)) begin
            res = {sign1_q, 31'd0};
        end else begin
            res = {sign1_q, e_f[EXP_W-1:0], frac};
        end

        v2_d = v1_q;
        m_d  = v1_q ? res : m_q;
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            exp1_q  <= '0;
            prod1_q <= '0;
            v2_q    <= 1'b0;
            m_q     <= '0;
        end else begin
            v1_q    <= v1_d;
            sign1_q <= sign1_d;
            nan1_q  <= nan1_d;
            inf1_q  <= inf1_d;
            zero1_q <= zero1_d;
            exp1_q  <= exp1_d;
            prod1_q <= prod1_d;
            v2_q    <= v2_d;
            m_q     <= m_d;
        end
    end

    assign out_valid = v2_q;
    assign m         = m_q;

endmodule

// File: tb/tb_fp32_mult.sv
// Testbench for fp32_mult: scoreboard of expected products checked as results emerge.
module tb_fp32_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] m;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_vec;
    int        n_err;
    int        run_len;
    int        last_run;

    fp32_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .m         (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result monitor: pops the scoreboard whenever a valid product appears
    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (!rst_n) begin
            run_len = 0;
        end else if (out_valid) begin
            run_len = run_len + 1;
            n_vec = n_vec + 1;
            if (sb.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL result: unexpected out_valid with m=%08h, nothing outstanding", m);
            end else begin
                e = sb.pop_front();
                if (m !== e.exp) begin
                    n_err = n_err + 1;
                    $display("FAIL result: a=%08h b=%08h got m=%08h expected %08h", e.a, e.b, m, e.exp);
                end
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vexp);
        sb_entry_t e;
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        e.a   = va;
        e.b   = vb;
        e.exp = vexp;
        sb.push_back(e);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 32'h4020_0000 ^ 32'(i * 32'h0123_4567);
            b = 32'h4040_0000 + 32'(i);
            #1;
            n_vec = n_vec + 1;
            if (out_valid !== 1'b0) begin
                n_err = n_err + 1;
                $display("FAIL reset_valid: cycle %0d got %b expected 0", i, out_valid);
            end
            n_vec = n_vec + 1;
            if (m !== 32'h0) begin
                n_err = n_err + 1;
                $display("FAIL reset_m: cycle %0d got %08h expected 00000000", i, m);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        drive(32'h4020_0000, 32'h4040_0000, 32'h40F0_0000);
        idle(4);
    endtask

    task automatic test_rounding;
        drive(32'h4974_2400, 32'h4CEA_D734, 32'h56DF_F624);
        drive(32'hBF8C_CCCD, 32'h40A0_0000, 32'hC0B0_0000);
        // exact tie, odd lsb -> rounds up
        drive(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
        // exact tie, even lsb -> stays
        drive(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004);
        drive(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        idle(4);
    endtask

    task automatic test_specials;
        drive(32'h4040_0000, 32'h0000_0000, 32'h0000_0000);
        drive(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        drive(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        drive(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
        drive(32'hFFC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        drive(32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000);
        drive(32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000);
        drive(32'h8000_0000, 32'h4040_0000, 32'h8000_0000);
        drive(32'h7F80_0001, 32'h0000_0000, 32'h7FC0_0000);
        idle(4);
    endtask

    task automatic test_range;
        drive(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
        drive(32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        drive(32'h8080_0000, 32'h0080_0000, 32'h8000_0000);
        // largest and smallest normal exponents survive
        drive(32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000);
        drive(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000);
        // result exponent lands exactly on 0 -> flushed
        drive(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
        // result exponent lands exactly on 255 -> infinity
        drive(32'hFF00_0000, 32'h4000_0000, 32'hFF80_0000);
        idle(4);
    endtask

    task automatic test_back_to_back;
        last_run = 0;
        drive(32'h4020_0000, 32'h4040_0000, 32'h40F0_0000);
        drive(32'h4040_0000, 32'h0000_0000, 32'h0000_0000);
        drive(32'hBF8C_CCCD, 32'h40A0_0000, 32'hC0B0_0000);
        drive(32'h4974_2400, 32'h4CEA_D734, 32'h56DF_F624);
        idle(5);
        n_vec = n_vec + 1;
        if (last_run !== 4) begin
            n_err = n_err + 1;
            $display("FAIL b2b_run: consecutive out_valid cycles got %0d expected 4", last_run);
        end
    endtask

    task automatic test_reset_midstream;
        drive(32'h4020_0000, 32'h4040_0000, 32'h40F0_0000);
        drive(32'hBF8C_CCCD, 32'h40A0_0000, 32'hC0B0_0000);
        drive(32'h4974_2400, 32'h4CEA_D734, 32'h56DF_F624);
        #1;
        n_vec = n_vec + 1;
        if (out_valid !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL pre_reset_valid: got %b expected 1", out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec = n_vec + 1;
        if (out_valid !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL midreset_valid: got %b expected 0", out_valid);
        end
        n_vec = n_vec + 1;
        if (m !== 32'h0) begin
            n_err = n_err + 1;
            $display("FAIL midreset_m: got %08h expected 00000000", m);
        end
        // the two products still in flight are discarded
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec = n_vec + 1;
            if (out_valid !== 1'b0) begin
                n_err = n_err + 1;
                $display("FAIL post_reset_valid: cycle %0d got %b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        run_len  = 0;
        last_run = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        test_reset();
        test_rounding();
        test_specials();
        test_range();
        test_back_to_back();
        test_reset_midstream();

        n_vec = n_vec + 1;
        if (sb.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
